serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: computes {Cout, Sum} = A + B + Cin one bit per clock,
// LSB first, through a single full_adder. Control is a three-state FSM
// (IDLE, SHIFT, DONE) with registered Busy/Done/Sum/Cout outputs.
//
// Handshake: Start is sampled on each rising clk edge while in IDLE or DONE.
// When it is accepted, A/B/Cin are captured. Done pulses for exactly one
// cycle when Sum/Cout carry a new result. Start is ignored while the
// addition is in progress (SHIFT), and so are changes on A/B/Cin.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  // One-bit full add; purely combinational.
  always_comb begin
    s_o = a_i ^ b_i ^ c_i;
    c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
  end

endmodule

module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Busy,
  output logic         Done,
  output logic [1:0]   state_dbg
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  psum_q;
  logic [N-1:0]  psum_d;
  logic          carry_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last_bit;
  logic          fa_sum;
  logic          fa_cout;

  // The only arithmetic in the block: operand LSBs plus the running carry.
  full_adder u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_sum),
    .c_o (fa_cout)
  );

  // Next counter value and next partial sum; the final bit is the one
  // whose increment makes the counter reach N.
  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    psum_d   = {fa_sum, psum_q[N-1:1]};
    last_bit = (cnt_d == CW'(N));
  end

  assign state_dbg = state_q;

  // FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // DONE accepts Start exactly like IDLE, so requests can run back to back.
          Done <= 1'b0;
          Busy <= 1'b0;
          if (Start) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            cnt_q   <= '0;
            psum_q  <= '0;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          psum_q  <= psum_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_d;
          if (last_bit) begin
            // Publish the completed result; the final carry goes only to Cout.
            Sum     <= psum_d;
            Cout    <= fa_cout;
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state_q <= DONE;
          end else begin
            Busy <= 1'b1;
          end
        end
        default: begin
          Busy    <= 1'b0;
          Done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
